// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op encoding,
// control FSM states and a small op-decode helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      ZDIV = 2'b11
   } state_e;

   // Divide ops have op[1] set; op[0] selects unsigned.
   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_hilo_unit_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator.
// Multiply: conditional add of the multiplicand into the upper half, then a
//           right shift (the multiplier is consumed from acc[0]).
// Divide:   restoring trial subtract of the divisor from the partial
//           remainder, quotient bit shifted in at acc[0].
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opnd_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH-1:0] diff_s;
   logic             ge_s;

   // Single combinational step for whichever operation is in flight.
   always_comb begin
      sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      rem_sh_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff_s   = rem_sh_s[WIDTH-1:0] - opnd_i;
      ge_s     = (rem_sh_s >= {1'b0, opnd_i});
      acc_o    = acc_i;
      if (acc_i[0]) begin
         sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
      end else begin
         sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      end
      if (div_i) begin
         // Remainder stays below the divisor, so the low WIDTH bits of the
         // difference are exact whenever the trial subtract succeeds.
         if (ge_s) begin
            acc_o = {diff_s, acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {sum_s, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multicycle signed/unsigned multiply/divide unit with architectural HI/LO
// registers, start/done handshake, abort and direct MTHI/MTLO writes.
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
   localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               div_q, div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               sa_s, sb_s;
   logic [WIDTH-1:0]   abs_a_s, abs_b_s;
   logic [2*WIDTH-1:0] step_acc_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_i  (div_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc_s)
   );

   // Operand magnitudes and sign-corrected results.
   always_comb begin
      sa_s    = ~op[0] & a[WIDTH-1];
      sb_s    = ~op[0] & b[WIDTH-1];
      abs_a_s = sa_s ? (ZERO_W - a) : a;
      abs_b_s = sb_s ? (ZERO_W - b) : b;
      prod_s  = neg_res_q ? (ZERO_2W - acc_q) : acc_q;
      quo_s   = neg_res_q ? (ZERO_W - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_s   = neg_rem_q ? (ZERO_W - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
   end

   // Control FSM next state and datapath next values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;
      case (state_q)
         IDLE: begin
            // Direct writes land now; a result started this cycle overwrites later.
            if (wr_hi) begin
               hi_d = wr_data;
            end else begin
               hi_d = hi_q;
            end
            if (wr_lo) begin
               lo_d = wr_data;
            end else begin
               lo_d = lo_q;
            end
            if (start) begin
               if (is_div(op) && (b == ZERO_W)) begin
                  state_d = ZDIV;
                  done_d  = 1'b1;
                  dz_d    = 1'b1;
               end else begin
                  state_d   = RUN;
                  cnt_d     = CNT_W'(WIDTH);
                  div_d     = is_div(op);
                  neg_res_d = sa_s ^ sb_s;
                  neg_rem_d = sa_s;
                  if (is_div(op)) begin
                     opnd_d = abs_b_s;
                     acc_d  = {ZERO_W, abs_a_s};
                  end else begin
                     opnd_d = abs_a_s;
                     acc_d  = {ZERO_W, abs_b_s};
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               acc_d = step_acc_s;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = FIX;
               end else begin
                  state_d = RUN;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            if (abort) begin
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
               if (div_q) begin
                  hi_d = rem_s;
                  lo_d = quo_s;
               end else begin
                  hi_d = prod_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_s[WIDTH-1:0];
               end
            end
         end
         ZDIV: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN) || (state_d == FIX);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= CNT_ZERO;
         acc_q     <= ZERO_2W;
         opnd_q    <= ZERO_W;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= ZERO_W;
         lo_q      <= ZERO_W;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_hilo_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start32, abort32, wr_hi32, wr_lo32;
   logic [1:0]  op32;
   logic [31:0] a32, b32, wr_data32, hi32, lo32;
   logic        busy32, done32, dz32;
   logic        start8, abort8, wr_hi8, wr_lo8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, wr_data8, hi8, lo8;
   logic        busy8, done8, dz8;

   int total = 0;
   int bad   = 0;

   muldiv_hilo_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
      .abort(abort32), .wr_hi(wr_hi32), .wr_lo(wr_lo32), .wr_data(wr_data32),
      .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
   );

   muldiv_hilo_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .abort(abort8), .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8),
      .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec32_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b, hi, lo;
   } vec8_t;

   vec32_t v32[8];
   vec8_t  v8[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic go32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op32 = o; a32 = x; b32 = y; start32 = 1'b1;
      tick();
      start32 = 1'b0;
   endtask

   task automatic go8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      tick();
      start8 = 1'b0;
   endtask

   // Waits for done; lat is the cycle index (start cycle = 0) where done is seen.
   task automatic wait_done32(input int from, output int lat, output int bcnt);
      lat = from; bcnt = 0;
      while (done32 !== 1'b1 && lat < 200) begin
         if (busy32 === 1'b1) bcnt++;
         tick();
         lat++;
      end
      if (done32 !== 1'b1) lat = -1;
   endtask

   task automatic wait_done8(input int from, output int lat, output int bcnt);
      lat = from; bcnt = 0;
      while (done8 !== 1'b1 && lat < 200) begin
         if (busy8 === 1'b1) bcnt++;
         tick();
         lat++;
      end
      if (done8 !== 1'b1) lat = -1;
   endtask

   initial begin
      int lat, bcnt, seen;

      v32[0] = '{OP_MULT,  32'hFFFFFFFB, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFDD};
      v32[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v32[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v32[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v32[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      v32[5] = '{OP_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      v32[6] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      v32[7] = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C};

      v8[0] = '{OP_MULT,  8'hFB, 8'h07, 8'hFF, 8'hDD};
      v8[1] = '{OP_DIV,   8'hF9, 8'h02, 8'hFF, 8'hFD};
      v8[2] = '{OP_DIV,   8'h80, 8'hFF, 8'h00, 8'h80};
      v8[3] = '{OP_DIVU,  8'd100, 8'd7, 8'd2,  8'd14};
      v8[4] = '{OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01};

      rst = 1'b1;
      start32 = 1'b0; abort32 = 1'b0; wr_hi32 = 1'b0; wr_lo32 = 1'b0;
      op32 = 2'b00; a32 = 32'h0; b32 = 32'h0; wr_data32 = 32'h0;
      start8 = 1'b0; abort8 = 1'b0; wr_hi8 = 1'b0; wr_lo8 = 1'b0;
      op8 = 2'b00; a8 = 8'h0; b8 = 8'h0; wr_data8 = 8'h0;
      tick();
      tick();
      chk("rst_hi32", hi32, 0);   chk("rst_lo32", lo32, 0);
      chk("rst_busy32", busy32, 0); chk("rst_done32", done32, 0);
      chk("rst_dz32", dz32, 0);
      chk("rst_hi8", hi8, 0);     chk("rst_lo8", lo8, 0);
      chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
      chk("rst_dz8", dz8, 0);
      rst = 1'b0;
      tick();

      // Table-driven results at WIDTH=32.
      for (int i = 0; i < 8; i++) begin
         go32(v32[i].op, v32[i].a, v32[i].b);
         wait_done32(1, lat, bcnt);
         chk($sformatf("v32[%0d]_lat", i), lat, 34);
         chk($sformatf("v32[%0d]_busy_cycles", i), bcnt, 33);
         chk($sformatf("v32[%0d]_dz", i), dz32, 0);
         chk($sformatf("v32[%0d]_hi", i), hi32, v32[i].hi);
         chk($sformatf("v32[%0d]_lo", i), lo32, v32[i].lo);
         tick();
         chk($sformatf("v32[%0d]_done_pulse", i), done32, 0);
      end

      // Divide by zero with preloaded HI/LO.
      wr_hi32 = 1'b1; wr_data32 = 32'h11;
      tick();
      wr_hi32 = 1'b0; wr_lo32 = 1'b1; wr_data32 = 32'h22;
      tick();
      wr_lo32 = 1'b0;
      chk("mthi", hi32, 32'h11);
      chk("mtlo", lo32, 32'h22);
      go32(OP_DIVU, 32'd100, 32'd0);
      chk("zdiv_done", done32, 1);
      chk("zdiv_dz", dz32, 1);
      chk("zdiv_busy", busy32, 0);
      chk("zdiv_hi", hi32, 32'h11);
      chk("zdiv_lo", lo32, 32'h22);
      tick();
      chk("zdiv_done_clr", done32, 0);
      chk("zdiv_dz_clr", dz32, 0);

      // Start while busy is ignored.
      go32(OP_MULT, 32'd3, 32'd5);
      repeat (4) tick();
      op32 = OP_DIVU; a32 = 32'd7; b32 = 32'd9; start32 = 1'b1;
      tick();
      start32 = 1'b0;
      wait_done32(6, lat, bcnt);
      chk("ign_lat", lat, 34);
      chk("ign_hi", hi32, 32'd0);
      chk("ign_lo", lo32, 32'd15);
      tick();

      // Abort at cycle 10.
      go32(OP_MULT, 32'd2, 32'd2);
      repeat (9) tick();
      abort32 = 1'b1;
      tick();
      abort32 = 1'b0;
      chk("abort_busy", busy32, 0);
      seen = 0;
      repeat (40) begin
         if (done32 === 1'b1) seen = 1;
         tick();
      end
      chk("abort_no_done", seen, 0);
      chk("abort_hi", hi32, 32'd0);
      chk("abort_lo", lo32, 32'd15);

      // MTLO while busy is dropped; HI/LO hold during the run.
      go32(OP_DIVU, 32'd100, 32'd7);
      repeat (11) tick();
      wr_lo32 = 1'b1; wr_data32 = 32'hDEAD;
      tick();
      wr_lo32 = 1'b0;
      chk("busy_wr_hold", lo32, 32'd15);
      wait_done32(13, lat, bcnt);
      chk("busy_wr_lat", lat, 34);
      chk("busy_wr_hi", hi32, 32'd2);
      chk("busy_wr_lo", lo32, 32'd14);
      tick();

      // MTHI together with start: write lands, result overwrites.
      wr_hi32 = 1'b1; wr_data32 = 32'hAAAA;
      go32(OP_MULTU, 32'd6, 32'd7);
      wr_hi32 = 1'b0;
      chk("wr_start_hi", hi32, 32'hAAAA);
      wait_done32(1, lat, bcnt);
      chk("wr_start_res_hi", hi32, 32'd0);
      chk("wr_start_res_lo", lo32, 32'd42);
      tick();

      // Reset at cycle 20 of a DIV.
      go32(OP_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy32, 0);
      chk("midrst_hi", hi32, 0);
      chk("midrst_lo", lo32, 0);
      chk("midrst_done", done32, 0);
      seen = 0;
      repeat (40) begin
         if (done32 === 1'b1) seen = 1;
         tick();
      end
      chk("midrst_no_done", seen, 0);

      // Table-driven results at WIDTH=8.
      for (int i = 0; i < 5; i++) begin
         go8(v8[i].op, v8[i].a, v8[i].b);
         wait_done8(1, lat, bcnt);
         chk($sformatf("v8[%0d]_lat", i), lat, 10);
         chk($sformatf("v8[%0d]_busy_cycles", i), bcnt, 9);
         chk($sformatf("v8[%0d]_hi", i), hi8, v8[i].hi);
         chk($sformatf("v8[%0d]_lo", i), lo8, v8[i].lo);
         tick();
         chk($sformatf("v8[%0d]_done_pulse", i), done8, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
